// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
//   Shares one single-precision multiplier among N_REQ requesters. Each cycle
//   the first eligible requester at or after the round-robin pointer wins.
//   Its operand pair is registered onto the multiplier inputs. A {valid, id}
//   tag travels MUL_LAT stages alongside the multiplier so that the product
//   can be returned with the id of the requester that issued it. A requester
//   may have only one operation outstanding (pend bit) at any time.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req        per-requester request level
//   op_a/op_b  packed operands, requester i in bits [32i+31:32i]
//   gnt        one-hot grant pulse, high the cycle after the issue edge
//   mul_a/b    registered operands driven to the external multiplier
//   mul_p      product returned by the multiplier (MUL_LAT-1 internal stages)
//   res_data   captured product
//   res_valid  one-cycle result strobe
//   res_id     requester owning res_data
//   idle       no operation pending or in flight
module fp_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 1,
  parameter int ID_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [32*N_REQ-1:0] op_a,
  input  logic [32*N_REQ-1:0] op_b,
  output logic [N_REQ-1:0]    gnt,
  output logic [31:0]         mul_a,
  output logic [31:0]         mul_b,
  input  logic [31:0]         mul_p,
  output logic [31:0]         res_data,
  output logic                res_valid,
  output logic [ID_W-1:0]     res_id,
  output logic                idle
);
  localparam int DATA_W = 32;

  logic [N_REQ-1:0]  pend;
  logic [N_REQ-1:0]  pend_nxt;
  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  gnt_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   cand;
  logic [ID_W:0]     sum;
  logic              win_vld;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [MUL_LAT-1:0] vld_p;
  logic [ID_W-1:0]   id_p [MUL_LAT];
  logic              cap_vld;
  logic [ID_W-1:0]   cap_id;

  // Eligibility uses the pre-edge pend, so a requester whose result is
  // captured on this edge can only be regranted on the next one.
  assign elig    = req & ~pend;
  assign cap_vld = vld_p[MUL_LAT-1];
  assign cap_id  = id_p[MUL_LAT-1];
  assign idle    = (pend == '0);

  // Round-robin search: walk N_REQ candidates starting at ptr, wrapping
  // modulo N_REQ (which need not be a power of two).
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int j = 0; j < N_REQ; j++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(j);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      cand = sum[ID_W-1:0];
      if (!win_vld && elig[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Operand select and one-hot grant for the winner.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    gnt_nxt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_vld && (win == ID_W'(i))) begin
        sel_a      = op_a[32*i +: 32];
        sel_b      = op_b[32*i +: 32];
        gnt_nxt[i] = 1'b1;
      end
    end
  end

  // Capture and issue never touch the same bit: a winner has pend=0 while a
  // captured id has pend=1.
  always_comb begin
    pend_nxt = pend;
    if (cap_vld) pend_nxt[cap_id] = 1'b0;
    pend_nxt = pend_nxt | gnt_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      pend      <= '0;
      ptr       <= '0;
      vld_p     <= '0;
      for (int s = 0; s < MUL_LAT; s++) id_p[s] <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else begin
      // ---- issue stage: grant, operand registers, pointer ----
      gnt  <= gnt_nxt;
      pend <= pend_nxt;
      if (win_vld) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
        ptr   <= (win == ID_W'(N_REQ-1)) ? '0 : win + 1'b1;
      end
      // ---- tag pipeline: mirrors the multiplier latency ----
      vld_p[0] <= win_vld;
      id_p[0]  <= win;
      for (int s = 1; s < MUL_LAT; s++) begin
        vld_p[s] <= vld_p[s-1];
        id_p[s]  <= id_p[s-1];
      end
      // ---- capture stage: product returned with its owner ----
      res_valid <= cap_vld;
      if (cap_vld) begin
        res_data <= mul_p;
        res_id   <= cap_id;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Testbench for fp_mul_arbiter: two instances (MUL_LAT=1 and MUL_LAT=3) share
// the same stimulus; each has its own stand-in multiplier. A transaction-level
// reference model schedules each issued product for delivery MUL_LAT cycles
// later and tracks which requesters are outstanding.
module tb_fp_mul_arbiter;
  localparam int N = 4;
  localparam logic [103:0] RST_VEC = {39'd0, 1'b1, 64'd0};

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic [32*N-1:0] op_a;
  logic [32*N-1:0] op_b;
  logic [N-1:0]  gnt1, gnt3;
  logic [31:0]   ma1, mb1, mp1, rd1;
  logic [31:0]   ma3, mb3, mp3, rd3;
  logic [31:0]   s1, s2;
  logic          rv1, rv3, idle1, idle3;
  logic [1:0]    rid1, rid3;
  logic [103:0]  obs [2];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [N-1:0]  m_pend [2];
  int            m_ptr  [2];
  int            cyc;
  logic          dv  [2][16];
  logic [1:0]    did [2][16];
  logic [31:0]   dp  [2][16];
  logic [N-1:0]  e_gnt [2];
  logic          e_rv  [2];
  logic [1:0]    e_rid [2];
  logic [31:0]   e_rd  [2];
  logic [31:0]   e_ma  [2];
  logic [31:0]   e_mb  [2];

  // Stand-in multiplier: normal operands only, truncating.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (m[47]) return {a[31] ^ b[31], e[7:0] + 8'd1, m[46:24]};
    return {a[31] ^ b[31], e[7:0], m[45:23]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    e = 8'($urandom_range(150, 100));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  function automatic logic [103:0] expv(input int m);
    return {e_gnt[m], e_rv[m], e_rid[m], e_rd[m], (m_pend[m] == '0), e_ma[m], e_mb[m]};
  endfunction

  function automatic void model_clear();
    cyc = 0;
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = '0; m_ptr[m] = 0;
      e_gnt[m] = '0; e_rv[m] = 1'b0; e_rid[m] = '0; e_rd[m] = '0; e_ma[m] = '0; e_mb[m] = '0;
      for (int s = 0; s < 16; s++) begin dv[m][s] = 1'b0; did[m][s] = '0; dp[m][s] = '0; end
    end
  endfunction

  function automatic void model_step();
    logic [3:0] s;
    logic [3:0] t;
    int lat;
    int w;
    int idx;
    int tsum;
    logic [N-1:0] elig;
    logic [N-1:0] sh;
    logic [32*N-1:0] wa;
    logic [32*N-1:0] wb;
    s = cyc[3:0];
    for (int m = 0; m < 2; m++) begin
      lat  = (m == 0) ? 1 : 3;
      elig = req & ~m_pend[m];
      w = -1;
      for (int j = 0; j < N; j++) begin
        idx = (m_ptr[m] + j) % N;
        sh  = elig >> idx;
        if (w < 0 && sh[0]) w = idx;
      end
      e_rv[m] = dv[m][s];
      if (dv[m][s]) begin
        e_rid[m]  = did[m][s];
        e_rd[m]   = dp[m][s];
        m_pend[m] = m_pend[m] & ~(4'b0001 << did[m][s]);
        dv[m][s]  = 1'b0;
      end
      e_gnt[m] = '0;
      if (w >= 0) begin
        e_gnt[m]  = 4'b0001 << w;
        wa = op_a >> (32 * w);
        wb = op_b >> (32 * w);
        e_ma[m]   = wa[31:0];
        e_mb[m]   = wb[31:0];
        m_pend[m] = m_pend[m] | (4'b0001 << w);
        m_ptr[m]  = (w + 1) % N;
        tsum = cyc + lat;
        t = tsum[3:0];
        dv[m][t]  = 1'b1;
        did[m][t] = 2'(w);
        dp[m][t]  = fmul(e_ma[m], e_mb[m]);
      end
    end
    cyc++;
  endfunction

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_clear();
      else model_step();
    end
  end

  assign mp1 = fmul(ma1, mb1);
  always @(posedge clk) begin
    s1 <= fmul(ma3, mb3);
    s2 <= s1;
  end
  assign mp3 = s2;

  always_comb begin
    obs[0] = {gnt1, rv1, rid1, rd1, idle1, ma1, mb1};
    obs[1] = {gnt3, rv3, rid3, rd3, idle3, ma3, mb3};
  end

  fp_mul_arbiter #(.N_REQ(N), .MUL_LAT(1), .ID_W(2)) u1 (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt1), .mul_a(ma1), .mul_b(mb1), .mul_p(mp1),
    .res_data(rd1), .res_valid(rv1), .res_id(rid1), .idle(idle1));

  fp_mul_arbiter #(.N_REQ(N), .MUL_LAT(3), .ID_W(2)) u3 (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt3), .mul_a(ma3), .mul_b(mb3), .mul_p(mp3),
    .res_data(rd3), .res_valid(rv3), .res_id(rid3), .idle(idle3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic rnd_ops();
    for (int i = 0; i < N; i++) begin
      op_a[32*i +: 32] = rnd_fp();
      op_b[32*i +: 32] = rnd_fp();
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== RST_VEC) begin
        errors++; $display("FAIL reset_state m=%0d got %h want %h", m, obs[m], RST_VEC);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== RST_VEC) begin
        errors++; $display("FAIL reset_release m=%0d got %h want %h", m, obs[m], RST_VEC);
      end
    end
  endtask

  task automatic test_single();
    op_a[31:0] = 32'h4000_0000;
    op_b[31:0] = 32'h4040_0000;
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt1 !== 4'b0001 || ma1 !== 32'h4000_0000 || mb1 !== 32'h4040_0000 || idle1 !== 1'b0) begin
      errors++; $display("FAIL single_grant got gnt=%b a=%h b=%h idle=%b want 0001 40000000 40400000 0", gnt1, ma1, mb1, idle1);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (rv1 !== 1'b1 || rd1 !== 32'h40C0_0000 || rid1 !== 2'd0 || idle1 !== 1'b1 || gnt1 !== 4'b0000) begin
      errors++; $display("FAIL single_result got v=%b d=%h id=%0d idle=%b gnt=%b want 1 40c00000 0 1 0000", rv1, rd1, rid1, idle1, gnt1);
    end
    for (int k = 0; k < 4; k++) begin
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv(m)) begin
          errors++; $display("FAIL single_model m=%0d k=%0d got %h want %h", m, k, obs[m], expv(m));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (rd3 !== 32'h40C0_0000 || rid3 !== 2'd0 || idle3 !== 1'b1) begin
      errors++; $display("FAIL single_lat3 got d=%h id=%0d idle=%b want 40c00000 0 1", rd3, rid3, idle3);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seen;
    seen = '0;
    pulse_reset();
    rnd_ops();
    req = 4'b1111;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      checks++;
      if (gnt1 !== (4'b0001 << (k % 4))) begin
        errors++; $display("FAIL rr_order k=%0d got %b want %b", k, gnt1, 4'b0001 << (k % 4));
      end
      if (gnt3 != '0) begin
        checks++;
        if ((seen & gnt3) != '0) begin
          errors++; $display("FAIL rr_fair k=%0d got gnt=%b already served %b", k, gnt3, seen);
        end
        seen = seen | gnt3;
        if (seen == 4'b1111) seen = '0;
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv(m)) begin
          errors++; $display("FAIL rr_model m=%0d k=%0d got %h want %h", m, k, obs[m], expv(m));
        end
      end
      rnd_ops();
    end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] eg;
    logic         ev;
    logic [1:0]   eid;
    pulse_reset();
    rnd_ops();
    req = 4'b0110;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      eg  = (k == 0) ? 4'b0010 : (k == 1) ? 4'b0100 : 4'b0000;
      ev  = (k == 3) || (k == 4);
      eid = (k == 4) ? 2'd2 : 2'd1;
      checks++;
      if (gnt3 !== eg || rv3 !== ev || (ev && rid3 !== eid)) begin
        errors++; $display("FAIL b2b_lat3 k=%0d got gnt=%b v=%b id=%0d want gnt=%b v=%b id=%0d", k, gnt3, rv3, rid3, eg, ev, eid);
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv(m)) begin
          errors++; $display("FAIL b2b_model m=%0d k=%0d got %h want %h", m, k, obs[m], expv(m));
        end
      end
      if (k == 1) req = '0;
    end
  endtask

  task automatic test_regrant_period();
    int last_g [2];
    int last_rv [2];
    int ngr [2];
    int lat;
    logic [103:0] o;
    pulse_reset();
    rnd_ops();
    req = 4'b0001;
    for (int m = 0; m < 2; m++) begin last_g[m] = -1; last_rv[m] = -100; ngr[m] = 0; end
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        lat = (m == 0) ? 1 : 3;
        o = obs[m];
        if (o[100]) begin
          ngr[m]++;
          if (last_g[m] >= 0) begin
            checks++;
            if (k - last_g[m] != lat + 1) begin
              errors++; $display("FAIL regrant_period m=%0d got %0d want %0d", m, k - last_g[m], lat + 1);
            end
            checks++;
            if (last_rv[m] != k - 1) begin
              errors++; $display("FAIL regrant_after_result m=%0d got result at %0d want %0d", m, last_rv[m], k - 1);
            end
          end
          last_g[m] = k;
        end
        if (o[99]) last_rv[m] = k;
        checks++;
        if (o !== expv(m)) begin
          errors++; $display("FAIL regrant_model m=%0d k=%0d got %h want %h", m, k, o, expv(m));
        end
      end
      rnd_ops();
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ngr[m] < 4) begin
        errors++; $display("FAIL regrant_count m=%0d got %0d want >=4", m, ngr[m]);
      end
    end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    pulse_reset();
    rnd_ops();
    req = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv(m)) begin
          errors++; $display("FAIL inflight_model m=%0d k=%0d got %h want %h", m, k, obs[m], expv(m));
        end
      end
    end
    req = '0;
    #2 reset = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs[m] !== RST_VEC) begin
        errors++; $display("FAIL inflight_async_clear m=%0d got %h want %h", m, obs[m], RST_VEC);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (rv1 !== 1'b0 || rv3 !== 1'b0 || idle3 !== 1'b1) begin
        errors++; $display("FAIL inflight_dropped k=%0d got v1=%b v3=%b idle3=%b want 0 0 1", k, rv1, rv3, idle3);
      end
    end
    req = 4'b1111;
    @(negedge clk);
    checks++;
    if (gnt1 !== 4'b0001 || gnt3 !== 4'b0001) begin
      errors++; $display("FAIL inflight_ptr_restart got %b %b want 0001 0001", gnt1, gnt3);
    end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_idle_hold();
    logic [31:0] sa [2];
    logic [31:0] sb [2];
    logic [103:0] o;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rnd_ops();
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs[m] !== expv(m)) begin
          errors++; $display("FAIL idle_active_model m=%0d k=%0d got %h want %h", m, k, obs[m], expv(m));
        end
      end
    end
    req = '0;
    for (int m = 0; m < 2; m++) begin sa[m] = e_ma[m]; sb[m] = e_mb[m]; end
    for (int k = 0; k < 10; k++) begin
      rnd_ops();
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        o = obs[m];
        checks++;
        if (o[103:100] !== 4'b0000 || (k >= 3 && o[99] !== 1'b0) || o[63:32] !== sa[m] || o[31:0] !== sb[m]) begin
          errors++; $display("FAIL idle_hold m=%0d k=%0d got gnt=%b v=%b a=%h b=%h want 0000 0 %h %h", m, k, o[103:100], o[99], o[63:32], o[31:0], sa[m], sb[m]);
        end
        checks++;
        if (o !== expv(m)) begin
          errors++; $display("FAIL idle_model m=%0d k=%0d got %h want %h", m, k, o, expv(m));
        end
      end
    end
    checks++;
    if (idle1 !== 1'b1 || idle3 !== 1'b1) begin
      errors++; $display("FAIL idle_flag got %b %b want 1 1", idle1, idle3);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_regrant_period();
    test_reset_inflight();
    test_idle_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one IEEE-754 single-precision multiplier among N_REQ requesters. Requesters are the Jacobi rotation lanes computing c*a_pq, s*a_pq, 2.0*x and similar products.
- Arbitrates round-robin, registers the winning operand pair onto the multiplier inputs, and tracks in-flight operations through a tag pipeline.
- Returns each product with the ID of the requester that issued it.
- Sits between the rotation sequencer lanes and the single multiplier instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MUL_LAT, 1, edges from issue to result capture. The external multiplier has MUL_LAT-1 internal register stages; 1 means a combinational multiplier. Range 1..8.
- ID_W, 2, width of res_id; must equal clog2(N_REQ).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- req, input, N_REQ, per-requester request level.
- op_a, input, 32*N_REQ, operand A; requester i uses bits [32i+31:32i].
- op_b, input, 32*N_REQ, operand B; same packing as op_a.
- gnt, output, N_REQ, one-hot grant pulse.
- mul_a, output, 32, registered operand A to the multiplier.
- mul_b, output, 32, registered operand B to the multiplier.
- mul_p, input, 32, product from the multiplier.
- res_data, output, 32, returned product.
- res_valid, output, 1, one-cycle result strobe.
- res_id, output, ID_W, requester owning res_data.
- idle, output, 1, high when nothing is pending or in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - gnt, res_valid, res_id, res_data, mul_a, mul_b all clear to 0.
  - pend, the tag pipeline and the round-robin pointer all clear.
  - idle is 1.
  - In-flight operations are discarded; no res_valid is ever produced for them.
  - Deassertion is sampled at the next rising edge.
- Eligibility: requester i is eligible when req[i]=1 and pend[i]=0. Each requester has at most one outstanding op.
- Issue edge, when any requester is eligible:
  - Winner k is the first eligible index at or after ptr, searched modulo N_REQ.
  - gnt is set to one-hot k; mul_a/mul_b take op_a[k]/op_b[k].
  - pend[k] is set, ptr becomes (k+1) mod N_REQ, and tag stage 0 takes {valid=1, id=k}.
- With no eligible requester: gnt=0, tag stage 0 valid=0, and mul_a/mul_b hold their values.
- gnt is high for exactly the cycle after the issue edge. The requester must hold operands stable while req=1 and un-granted. It may keep req high; pend blocks a regrant.
- Tag pipeline: MUL_LAT stages of {valid, id}, shifting every edge.
- Capture: at the edge where the last stage is valid, res_data<=mul_p, res_id<=id, res_valid<=1, and pend[id] clears. Otherwise res_valid<=0 and res_data/res_id hold.
- Latency: res_valid rises MUL_LAT edges after the issue edge and lasts one cycle.
- Throughput: one issue per cycle across distinct requesters. Back-to-back issues produce back-to-back results in issue order.
- Simultaneous events:
  - Capture clearing pend[i] and an issue on the same edge: eligibility uses the pre-edge pend, so i cannot be regranted on that edge. Its earliest regrant is the following edge, giving a per-requester period of MUL_LAT+1.
  - Issue and capture on the same edge for different requesters are both performed.
- idle = (pend == 0). No dedicated state machine; per-slot status is {pend, in-flight} via the tag pipeline.
- No arithmetic is performed on operands: pass-through only. Special values (NaN, Inf, zero) are the multiplier's concern.

Test Plan:
- Reset, then req=4'b0001, op_a=0x40000000 (2.0), op_b=0x40400000 (3.0), MUL_LAT=1 -> gnt=0001 one cycle after the first edge; res_valid with res_data=0x40C00000 (6.0), res_id=0 one edge later; idle returns to 1.
- req=4'b1111 held continuously, MUL_LAT=1 -> grant order 0,1,2,3,0... (each req is regranted once its result returns). No index is granted twice before all others are served; pend never exceeds one per requester.
- MUL_LAT=3, requesters 1 then 2 granted on consecutive edges -> results with res_id=1 then 2 on consecutive cycles, each 3 edges after its issue.
- Requester 0 holds req high continuously -> regranted exactly one edge after its res_valid, never earlier; period equals MUL_LAT+1 cycles.
- reset pulled low with 2 ops in flight (MUL_LAT=3) -> outputs cleared immediately, no res_valid for the dropped ops after release, and ptr restarts at 0.
- req=0 for 10 cycles after activity -> gnt=0, res_valid=0, and mul_a/mul_b hold their last values.
